niosiimicro_key_ctrl: RTL and testbench

NIOSIIMICRO_KEY_CTRL -- requirements
Module: niosiimicro_key_ctrl

---
 rtl/niosiimicro_key_ctrl_pkg.sv | 24 ++
 rtl/niosiimicro_key_ctrl_timer.sv | 39 +++
 rtl/niosiimicro_key_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_niosiimicro_key_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/niosiimicro_key_ctrl_pkg.sv
// Shared types and constants for the two-key PIO controller.
package niosiimicro_key_ctrl_pkg;

  localparam int unsigned NUM_KEYS = 2;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_MASK,
    ST_WAIT,
    ST_EMIT
  } state_e;

  // Interrupt mask that enables only the keys not listed in 'quiet'.
  function automatic logic [NUM_KEYS-1:0] irq_mask(input logic [NUM_KEYS-1:0] quiet);
    return ~quiet;
  endfunction

endpackage

// File: rtl/niosiimicro_key_ctrl_timer.sv
// Shared up-counter for debounce and poll intervals: load clears,
// en counts, done flags the last cycle of a 'limit'-cycle interval.
module niosiimicro_key_ctrl_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear on load, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = en && (cnt_q == limit - ONE);

endmodule

// File: rtl/niosiimicro_key_ctrl.sv
// Debounced two-key event source driving a Nios II key PIO.
// Optional build macro KEY_CTRL_GLITCH_CNT_EN adds an 8-bit saturating
// glitch counter output.
module niosiimicro_key_ctrl
  import niosiimicro_key_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned POLL_CYCLES     = 100000
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [1:0]          pio_address,
  output logic                pio_chipselect,
  output logic                pio_write_n,
  output logic [31:0]         pio_writedata,
  input  logic [31:0]         pio_readdata,
  input  logic                pio_irq,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [NUM_KEYS-1:0] evt_keys,
  output logic [NUM_KEYS-1:0] evt_changed
`ifdef KEY_CTRL_GLITCH_CNT_EN
  ,
  output logic [7:0]          glitch_cnt
`endif
);

  state_e state_q, state_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] cand_q, cand_d;
  logic [NUM_KEYS-1:0] chg_q, chg_d;
  logic [NUM_KEYS-1:0] mask_q, mask_d;
  logic                confirm_q, confirm_d;
  logic                to_wait_q, to_wait_d;
  logic                init_arm_q;

  logic [NUM_KEYS-1:0] sample, diff, conf;
  logic                timer_en, timer_done;
  logic [31:0]         timer_limit;
  logic                unused_rd_hi;

  // Upper PIO data bits carry no key state.
  assign unused_rd_hi = ^pio_readdata[31:NUM_KEYS];

  assign sample = pio_readdata[NUM_KEYS-1:0];
  assign diff   = sample ^ held_q;
  assign conf   = cand_q & diff;

  // Debounce runs in WAIT; release polling runs in IDLE while a key is held.
  assign timer_en    = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && (held_q != '0));
  assign timer_limit = (state_q == ST_WAIT) ? 32'(DEBOUNCE_CYCLES) : 32'(POLL_CYCLES);

  niosiimicro_key_ctrl_timer #(
    .WIDTH (32)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (!timer_en),
    .en      (timer_en),
    .limit   (timer_limit),
    .done    (timer_done)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    cand_d    = cand_q;
    chg_d     = chg_q;
    mask_d    = mask_q;
    confirm_d = confirm_q;
    to_wait_d = to_wait_q;
    case (state_q)
      ST_INIT: begin
        if (init_arm_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (pio_irq || timer_done) state_d = ST_RD_ADDR;
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (!confirm_q) begin
          cand_d = diff;
          if (diff == '0) begin
            state_d = ST_IDLE;
          end else begin
            mask_d    = irq_mask(held_q | diff);
            to_wait_d = 1'b1;
            state_d   = ST_WR_MASK;
          end
        end else begin
          confirm_d = 1'b0;
          if (conf != '0) begin
            held_d  = held_q ^ conf;
            chg_d   = conf;
            state_d = ST_EMIT;
          end else begin
            mask_d    = irq_mask(held_q);
            to_wait_d = 1'b0;
            state_d   = ST_WR_MASK;
          end
        end
      end
      ST_WR_MASK: state_d = to_wait_q ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (timer_done) begin
          confirm_d = 1'b1;
          state_d   = ST_RD_ADDR;
        end
      end
      ST_EMIT: begin
        if (evt_ready) begin
          mask_d    = irq_mask(held_q);
          to_wait_d = 1'b0;
          state_d   = ST_WR_MASK;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and datapath registers. init_arm_q holds off the INIT mask write
  // for one cycle so outputs sit at their idle values while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      held_q     <= '0;
      cand_q     <= '0;
      chg_q      <= '0;
      mask_q     <= '0;
      confirm_q  <= 1'b0;
      to_wait_q  <= 1'b0;
      init_arm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      cand_q     <= cand_d;
      chg_q      <= chg_d;
      mask_q     <= mask_d;
      confirm_q  <= confirm_d;
      to_wait_q  <= to_wait_d;
      init_arm_q <= 1'b1;
    end
  end

  // PIO bus and event outputs decoded from the current state.
  always_comb begin
    pio_address    = PIO_ADDR_DATA;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    case (state_q)
      ST_INIT: begin
        if (init_arm_q) begin
          pio_address    = PIO_ADDR_MASK;
          pio_chipselect = 1'b1;
          pio_write_n    = 1'b0;
          pio_writedata  = {{(32-NUM_KEYS){1'b0}}, irq_mask('0)};
        end
      end
      ST_RD_ADDR: begin
        pio_address    = PIO_ADDR_DATA;
        pio_chipselect = 1'b1;
      end
      ST_WR_MASK: begin
        pio_address    = PIO_ADDR_MASK;
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_writedata  = {{(32-NUM_KEYS){1'b0}}, mask_q};
      end
      default: ;
    endcase
    evt_valid   = (state_q == ST_EMIT);
    evt_keys    = held_q;
    evt_changed = chg_q;
  end

`ifdef KEY_CTRL_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;

  // Count confirm reads that found no surviving change, saturating at 255.
  always_comb begin
    glitch_d = glitch_q;
    if ((state_q == ST_RD_DATA) && confirm_q && (conf == '0) && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  // Glitch counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_niosiimicro_key_ctrl.sv
// Self-checking bench for niosiimicro_key_ctrl with a behavioural key PIO.
module tb_niosiimicro_key_ctrl;

  localparam int unsigned DEB  = 8;
  localparam int unsigned POLL = 12;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata = '0;
  logic        pio_irq;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [1:0]  evt_keys;
  logic [1:0]  evt_changed;
`ifdef KEY_CTRL_GLITCH_CNT_EN
  logic [7:0]  glitch_cnt;
`endif

  niosiimicro_key_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .POLL_CYCLES     (POLL)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .pio_irq        (pio_irq),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_keys       (evt_keys),
    .evt_changed    (evt_changed)
`ifdef KEY_CTRL_GLITCH_CNT_EN
    ,
    .glitch_cnt     (glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Key PIO model: physical keys, irq mask register, registered read data.
  logic [1:0] keys = 2'b00;
  logic [1:0] pio_mask = 2'b00;
  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) pio_mask <= pio_writedata[1:0];
    pio_readdata <= (pio_address == 2'd2) ? {30'b0, pio_mask} : {30'b0, keys};
  end
  assign pio_irq = |(keys & pio_mask);

  // Bus monitor: log writes, read strobes and accepted events.
  int unsigned cyc = 0;
  logic [1:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int unsigned wr_t[$];
  int unsigned rd_t[$];
  int unsigned ev_n = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (reset_n) begin
      if (pio_chipselect && !pio_write_n) begin
        wr_addr.push_back(pio_address);
        wr_data.push_back(pio_writedata);
        wr_t.push_back(cyc);
      end
      if (pio_chipselect && pio_write_n) rd_t.push_back(cyc);
      if (evt_valid && evt_ready) ev_n++;
    end
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference state: debounced keys as the spec defines them, events expected so far.
  logic [1:0]  m_held = 2'b00;
  int unsigned exp_ev = 0;
  int unsigned last_wr_t = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] exp_data, input int unsigned budget);
    int unsigned n = 0;
    while (wr_data.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(wr_data.size() != 0), 32'd1);
    if (wr_data.size() != 0) begin
      last_wr_t = wr_t.pop_front();
      chk({tag, "_addr"}, 32'(wr_addr.pop_front()), 32'd2);
      chk({tag, "_data"}, wr_data.pop_front(), exp_data);
    end
  endtask

  task automatic expect_event(input string tag, input logic [1:0] k, input logic [1:0] c,
                              input int unsigned hold);
    int unsigned n = 0;
    while (!evt_valid && n < DEB + 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    if (evt_valid) begin
      chk({tag, "_debounced"}, 32'(cyc - last_wr_t >= DEB), 32'd1);
      chk({tag, "_keys"}, 32'(evt_keys), 32'(k));
      chk({tag, "_changed"}, 32'(evt_changed), 32'(c));
      for (int i = 0; i < int'(hold); i++) begin
        tick();
        chk({tag, "_hold_valid"}, 32'(evt_valid), 32'd1);
        chk({tag, "_hold_kc"}, 32'({evt_keys, evt_changed}), 32'({k, c}));
      end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      exp_ev++;
      chk({tag, "_accepted"}, ev_n, exp_ev);
      chk({tag, "_drop"}, 32'(evt_valid), 32'd0);
    end
  endtask

  // Apply a steady new key pattern and expect the full debounce/event/rearm exchange.
  task automatic key_change(input string tag, input logic [1:0] nk, input int unsigned hold);
    logic [1:0] old = m_held;
    keys = nk;
    expect_write({tag, "_arm"}, {30'b0, ~(old | nk)}, POLL + 10);
    expect_event({tag, "_evt"}, nk, old ^ nk, hold);
    expect_write({tag, "_rearm"}, {30'b0, ~nk}, 10);
    m_held = nk;
  endtask

  task automatic expect_quiet(input string tag, input int unsigned n);
    repeat (n) tick();
    chk({tag, "_no_event"}, ev_n, exp_ev);
    chk({tag, "_no_valid"}, 32'(evt_valid), 32'd0);
    chk({tag, "_no_write"}, 32'(wr_data.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] nk;
    repeat (3) tick();
    chk("rst_cs",      32'(pio_chipselect), 32'd0);
    chk("rst_wn",      32'(pio_write_n),    32'd1);
    chk("rst_addr",    32'(pio_address),    32'd0);
    chk("rst_wdata",   pio_writedata,       32'd0);
    chk("rst_valid",   32'(evt_valid),      32'd0);
    chk("rst_keys",    32'(evt_keys),       32'd0);
    chk("rst_changed", 32'(evt_changed),    32'd0);
`ifdef KEY_CTRL_GLITCH_CNT_EN
    chk("rst_glitch",  32'(glitch_cnt),     32'd0);
`endif

    // Reset release: initial mask write of 3 within two cycles.
    reset_n = 1'b1;
    expect_write("init_mask", 32'd3, 2);
    expect_quiet("init", 10);

    // Short pulse on key0: armed, then rejected and rearmed.
    keys = 2'b01;
    repeat (4) tick();
    keys = 2'b00;
    expect_write("glitch_arm", 32'd2, 10);
    expect_write("glitch_rearm", 32'd3, DEB + 10);
`ifdef KEY_CTRL_GLITCH_CNT_EN
    chk("glitch_cnt", 32'(glitch_cnt), 32'd1);
`endif
    expect_quiet("glitch", 30);

    // Key0 pressed steady.
    key_change("k0_press", 2'b01, 0);

    // Polling period while key0 held, no bus writes.
    rd_t.delete();
    repeat (3 * (POLL + 2) + 4) tick();
    chk("poll_count", 32'(rd_t.size() >= 3), 32'd1);
    if (rd_t.size() >= 3) begin
      chk("poll_period0", rd_t[1] - rd_t[0], POLL + 2);
      chk("poll_period1", rd_t[2] - rd_t[1], POLL + 2);
    end
    chk("poll_no_write", 32'(wr_data.size()), 32'd0);

    // Key0 release found by polling.
    key_change("k0_release", 2'b00, 0);

    // Both keys together, consumer stalls 20 cycles.
    key_change("both_press", 2'b11, 20);
    key_change("both_release", 2'b00, 2);

    // Randomised steady changes, including simultaneous press and release.
    for (int i = 0; i < 8; i++) begin
      nk = m_held ^ 2'($urandom_range(1, 3));
      key_change("rand", nk, $urandom_range(0, 5));
    end
    expect_quiet("rand", 2 * POLL);

    // Reset asserted while debouncing a change.
    nk = m_held ^ 2'b10;
    keys = nk;
    expect_write("rstw_arm", {30'b0, ~(m_held | nk)}, POLL + 10);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("rstw_cs",      32'(pio_chipselect), 32'd0);
    chk("rstw_wn",      32'(pio_write_n),    32'd1);
    chk("rstw_addr",    32'(pio_address),    32'd0);
    chk("rstw_wdata",   pio_writedata,       32'd0);
    chk("rstw_valid",   32'(evt_valid),      32'd0);
    chk("rstw_keys",    32'(evt_keys),       32'd0);
    chk("rstw_changed", 32'(evt_changed),    32'd0);
    keys = 2'b00;
    m_held = 2'b00;
    repeat (2) tick();
    reset_n = 1'b1;
    expect_write("rstw_init", 32'd3, 2);
    expect_quiet("rstw", 4 * DEB);
`ifdef KEY_CTRL_GLITCH_CNT_EN
    chk("rstw_glitch", 32'(glitch_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
